// File: rtl/program_feeder.sv
// Program memory plus fetch sequencer that feeds instruction and immediate words to the processor din port.
// Latency: a start enters INSTR at the next edge, and mem[pc] drives din combinationally while running.
// Backpressure: none; the sequencer only steps on the processor's one-hot tick.
module program_feeder #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        tick,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [8:0]        wr_data,
  input  logic              start,
  output logic [8:0]        din,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              imm_phase
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_INSTR, S_IMM, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              imm_armed, imm_armed_nxt;
  logic [8:0]        mem [DEPTH];
  logic [8:0]        word;
  logic [2:0]        opcode;
  logic              stopped;

  assign word    = mem[pc];
  assign opcode  = word[8:6];
  assign stopped = (state == S_IDLE) || (state == S_DONE);

  // The program image is frozen while the sequencer is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && stopped) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      imm_armed <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      imm_armed <= imm_armed_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    imm_armed_nxt = imm_armed;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_INSTR;
          pc_nxt    = '0;
        end
      end
      S_INSTR: begin
        if (tick == 4'b1000) begin
          case (opcode)
            3'b000: state_nxt = S_DONE;
            3'b111, 3'b010: begin
              state_nxt     = S_IMM;
              pc_nxt        = pc + 1'b1;
              imm_armed_nxt = 1'b0;
            end
            default: pc_nxt = pc + 1'b1;
          endcase
        end
      end
      S_IMM: begin
        // A tick=0100 seen before any other tick belongs to the previous
        // step, so the immediate is held until a fresh 0100 edge.
        if (tick == 4'b0100 && imm_armed) begin
          state_nxt = S_INSTR;
          pc_nxt    = pc + 1'b1;
        end else if (tick != 4'b0100) begin
          imm_armed_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_INSTR) || (state == S_IMM);
    done      = (state == S_DONE);
    imm_phase = (state == S_IMM);
    din       = busy ? word : 9'h000;
  end

endmodule

// File: tb/tb_program_feeder.sv
// Directed, table-driven bench for program_feeder with hand-computed expectations.
module tb_program_feeder;

  localparam int ADDR_W = 4;
  localparam logic [3:0] T1 = 4'b0001, T2 = 4'b0010, T4 = 4'b0100, T8 = 4'b1000;
  // Expected {busy, done, imm_phase}
  localparam logic [2:0] IDL = 3'b000, INS = 3'b100, IMM = 3'b101, DON = 3'b010;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        tick;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [8:0]        wr_data;
  logic              start;
  logic [8:0]        din;
  logic [ADDR_W-1:0] pc;
  logic              busy, done, imm_phase;

  int n_checks = 0;
  int n_pass   = 0;

  program_feeder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .din       (din),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .imm_phase (imm_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  tick;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        start;
    logic [8:0]  e_din;
    logic [3:0]  e_pc;
    logic [2:0]  e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] t, input logic we, input logic [3:0] wa,
                     input logic [8:0] wd, input logic s, input logic [8:0] ed,
                     input logic [3:0] ep, input logic [2:0] es);
    vec_t v;
    v.rst = r; v.tick = t; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.start = s;
    v.e_din = ed; v.e_pc = ep; v.e_st = es;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [8:0] ed, input logic [3:0] ep, input logic [2:0] es);
    n_checks++;
    if (din === ed && pc === ep && {busy, done, imm_phase} === es) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got din=%h pc=%0d busy/done/imm=%b, expected din=%h pc=%0d busy/done/imm=%b",
               nm, din, pc, {busy, done, imm_phase}, ed, ep, es);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] t, input logic we, input logic [3:0] wa,
                       input logic [8:0] wd, input logic s);
    rst = r; tick = t; wr_en = we; wr_addr = wa; wr_data = wd; start = s;
  endtask

  initial begin
    drive(1'b1, 4'b0000, 1'b0, 4'd0, 9'h000, 1'b0);

    // Reset, then load movi R1,5 / add R1,R1 / halt; mem[0] written with the start
    add(1, 4'b0000, 0, 0, 9'h000, 0, 9'h000, 0, IDL);
    add(0, T1, 1, 1, 9'h005, 0, 9'h000, 0, IDL);
    add(0, T2, 1, 2, 9'h049, 0, 9'h000, 0, IDL);
    add(0, T4, 1, 3, 9'h000, 0, 9'h000, 0, IDL);
    add(0, T1, 1, 0, 9'h1C8, 1, 9'h1C8, 0, INS);
    add(0, T2, 0, 0, 9'h000, 0, 9'h1C8, 0, INS);
    add(0, T4, 0, 0, 9'h000, 0, 9'h1C8, 0, INS);
    add(0, 4'b0000, 0, 0, 9'h000, 0, 9'h1C8, 0, INS);
    add(0, 4'b1100, 0, 0, 9'h000, 0, 9'h1C8, 0, INS);
    add(0, T8, 0, 0, 9'h000, 0, 9'h005, 1, IMM);
    add(0, T4, 0, 0, 9'h000, 0, 9'h005, 1, IMM);    // stale 0100 right after entry
    add(0, T1, 1, 2, 9'h1FF, 1, 9'h005, 1, IMM);    // write and start ignored
    add(0, T2, 0, 0, 9'h000, 0, 9'h005, 1, IMM);
    add(0, T4, 0, 0, 9'h000, 0, 9'h049, 2, INS);
    add(0, T8, 0, 0, 9'h000, 0, 9'h000, 3, INS);
    add(0, T1, 1, 3, 9'h1C8, 0, 9'h000, 3, INS);
    add(0, T2, 0, 0, 9'h000, 0, 9'h000, 3, INS);
    add(0, T4, 0, 0, 9'h000, 0, 9'h000, 3, INS);
    add(0, T8, 0, 0, 9'h000, 0, 9'h000, 3, DON);
    add(0, T8, 0, 0, 9'h000, 0, 9'h000, 3, DON);

    // Wrap program: movi at 0, filler adds, addi at 15 whose immediate is mem[0]
    for (int i = 0; i < 16; i++) begin
      logic [8:0] d;
      d = (i == 0) ? 9'h1FF : (i == 1) ? 9'h000 : (i == 15) ? 9'h0BB : 9'h049;
      add(0, T1, 1, 4'(i), d, 0, 9'h000, 3, DON);
    end
    add(0, T1, 0, 0, 9'h000, 1, 9'h1FF, 0, INS);
    add(0, T8, 0, 0, 9'h000, 0, 9'h000, 1, IMM);
    add(0, T1, 0, 0, 9'h000, 0, 9'h000, 1, IMM);
    add(0, T4, 0, 0, 9'h000, 0, 9'h049, 2, INS);
    for (int k = 2; k <= 14; k++) begin
      add(0, T8, 0, 0, 9'h000, 0, (k == 14) ? 9'h0BB : 9'h049, 4'(k + 1), INS);
    end
    add(0, T8, 0, 0, 9'h000, 0, 9'h1FF, 0, IMM);
    add(0, T1, 0, 0, 9'h000, 0, 9'h1FF, 0, IMM);
    add(0, T2, 0, 0, 9'h000, 0, 9'h1FF, 0, IMM);
    add(0, T4, 0, 0, 9'h000, 0, 9'h000, 1, INS);
    add(0, T8, 0, 0, 9'h000, 0, 9'h000, 1, DON);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].tick, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].wr_data, vecs[i].start);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_din, vecs[i].e_pc, vecs[i].e_st);
    end

    // Reset in the middle of an immediate clears everything without an edge
    drive(0, T1, 0, 0, 9'h000, 1);
    @(posedge clk); #1;
    check("rerun_fetch", 9'h1FF, 0, INS);
    drive(0, T8, 0, 0, 9'h000, 0);
    @(posedge clk); #1;
    check("rerun_imm", 9'h000, 1, IMM);
    rst = 1'b1;
    #2;
    check("rst_async", 9'h000, 0, IDL);
    @(posedge clk); #1;
    drive(0, T8, 0, 0, 9'h000, 0);
    @(posedge clk); #1;
    check("no_restart", 9'h000, 0, IDL);
    drive(0, T1, 0, 0, 9'h000, 1);
    @(posedge clk); #1;
    check("cleared_fetch", 9'h000, 0, INS);
    drive(0, T8, 0, 0, 9'h000, 0);
    @(posedge clk); #1;
    check("cleared_halt", 9'h000, 0, DON);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
